spi_slave_regs: RTL and testbench
=================================

SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

Interface
REQ-001 SHALL have parameter ID_VALUE, default 8'hA5, read-only identification byte at address 0x7F.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on SCLK/MOSI/SS_n.
REQ-003 SHALL have ports: mclk_i_clk  in  1  system clock; single clock for the whole block.
REQ-004 SHALL have ports: mclk_reset_reset  in  1  reset, synchronous to mclk_i_clk, active-high.
REQ-005 SHALL have ports: spi_signals_i_SCLK  in  1  asynchronous SPI clock from master.
REQ-006 SHALL have ports: spi_signals_i_MOSI  in  1  asynchronous master-out data.
REQ-007 SHALL have ports: spi_signals_i_SS_n  in  1  asynchronous active-low select.
REQ-008 SHALL have ports: spi_signals_o_MISO  out  1  slave-out data; spi_signals_o_MISO_oe  out  1  MISO output enable.
REQ-009 SHALL have ports: status_i  in  32  status word readable at 0x08..0x0B (byte 0 = bits 7:0).
REQ-010 SHALL have ports: cfg_regs_o  out  64  eight config bytes, address n at bits 8n+7:8n.
REQ-011 SHALL have ports: wr_strobe_o  out  1  one-cycle pulse per committed write; wr_addr_o  out  3  address written.

Function
REQ-012 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first, 16-bit frames: bit15 R/nW (1=read), bits14:8 address, bits7:0 data.
REQ-013 SHALL sample SCLK, MOSI, SS_n through SYNC_STAGES flops, then detect SCLK edges from the last two synchronized samples; mclk_i_clk SHALL be at least 8x SCLK.
REQ-014 SHALL use FSM IDLE -> CMD (SS_n low seen) -> DATA (8th rising edge) -> DONE (16th rising edge) -> IDLE (SS_n high seen).
REQ-015 SHALL shift MOSI into the receive register on each synchronized rising SCLK edge in CMD and DATA.
REQ-016 SHALL drive MISO 0 during CMD, and during DATA of a write frame.
REQ-017 SHALL latch read data in the cycle the 8th rising edge is detected; status_i is snapshotted in that cycle.
REQ-018 SHALL present the read-data MSB on the falling edge after the 8th rising edge and shift on each subsequent falling edge.
REQ-019 SHALL decode read data: 0x00-0x07 cfg byte; 0x08-0x0B status_i byte; 0x7F ID_VALUE; all others 0x00.
REQ-020 SHALL commit a write to addresses 0x00-0x07 one cycle after the 16th rising edge is detected, pulsing wr_strobe_o with wr_addr_o valid in that same cycle.
REQ-021 SHALL ignore writes to any other address: no register change and no strobe.
REQ-022 SHALL assert MISO_oe only while synchronized SS_n is low.
REQ-023 SHALL, if SS_n rises before the 16th rising edge, discard the frame (no write, no strobe) and return to IDLE.
REQ-024 SHALL ignore SCLK edges beyond the 16th in DONE, holding MISO at 0.
REQ-025 SHALL ignore SCLK edges while SS_n is high.
REQ-026 SHALL update a cfg byte and its read-back in the same cycle; a read of an address SHALL return the value committed before that frame's 8th edge.

Reset
REQ-027 SHALL, on reset, set FSM=IDLE, shift/bit counters=0, cfg_regs_o=0, wr_strobe_o=0, wr_addr_o=0, MISO=0, MISO_oe=0.
REQ-028 SHALL load synchronizer flops to idle levels on reset: SCLK=0, MOSI=0, SS_n=1.
REQ-029 SHALL abort any in-flight frame when reset is asserted mid-frame: no write is committed and the block waits in IDLE for a fresh SS_n falling edge.

Structure
REQ-030 SHALL place the frame length (16), command width (8), address map constants (CFG_BASE 0x00, STATUS_BASE 0x08, ID_ADDR 0x7F) and the FSM state enum in shared package spi_slave_pkg.
REQ-031 SHALL instantiate one sub-module spi_sync_edge (synchronizer plus rise/fall detect) per asynchronous input line.

Verification
REQ-032 SHALL cover write: mclk=50 MHz, SCLK=5 MHz, frame 0x0312 -> cfg_regs_o[31:24]=0x12, one wr_strobe_o pulse with wr_addr_o=3.
REQ-033 SHALL cover read-back: frame 0x8300 after REQ-032 -> MISO bits 7:0 = 0x12, MISO=0 during bits 15:8.
REQ-034 SHALL cover ID and status: read 0xFF00 -> 0xA5; status_i=0xDEADBEEF, read 0x8A00 -> 0xAD; read 0x9000 -> 0x00.
REQ-035 SHALL cover abort: write 0x0555 with SS_n raised after 12 edges -> cfg byte 5 unchanged, no strobe; next full frame works.
REQ-036 SHALL cover unmapped write and overrun: write 0x2077 -> no strobe, cfg unchanged; 20-edge frame 0x0199 -> byte 1=0x99, exactly one strobe.
REQ-037 SHALL cover reset mid-frame: reset after 10 edges -> all outputs at reset values, no strobe; subsequent frame decodes correctly.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared constants, FSM state type and read-data decode for the SPI register slave.
`timescale 1ns/1ps
package spi_slave_pkg;

   localparam int FRAME_LEN  = 16;
   localparam int CMD_W      = 8;
   localparam int CNT_W      = 5;
   localparam int NUM_CFG    = 8;

   localparam logic [6:0] CFG_BASE    = 7'h00;
   localparam logic [6:0] STATUS_BASE = 7'h08;
   localparam logic [6:0] ID_ADDR     = 7'h7F;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_DATA,
      ST_DONE
   } state_e;

   // CFG_BASE and STATUS_BASE are aligned, so a prefix match selects the window.
   function automatic logic [7:0] read_byte(input logic [6:0]  addr,
                                            input logic [63:0] cfg,
                                            input logic [31:0] status,
                                            input logic [7:0]  id);
      logic [7:0] rd;
      rd = 8'h00;
      if (addr[6:3] == CFG_BASE[6:3]) begin
         rd = cfg[{addr[2:0], 3'b000} +: 8];
      end else if (addr[6:2] == STATUS_BASE[6:2]) begin
         rd = status[{addr[1:0], 3'b000} +: 8];
      end else if (addr == ID_ADDR) begin
         rd = id;
      end
      return rd;
   endfunction

endpackage

// File: rtl/spi_slave_regs_if.sv
// SPI pin bundle between an SPI master and the register slave.
`timescale 1ns/1ps
interface spi_slave_regs_if;

   logic SCLK;
   logic MOSI;
   logic SS_n;
   logic MISO;
   logic MISO_oe;

   modport slave  (input SCLK, MOSI, SS_n, output MISO, MISO_oe);
   modport master (output SCLK, MOSI, SS_n, input MISO, MISO_oe);

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous line, with rise/fall detect on
// the last two synchronized samples.
`timescale 1ns/1ps
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign q_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave exposing eight config bytes, a status word and an ID byte
// through 16-bit R/nW + address + data frames.
`timescale 1ns/1ps
module spi_slave_regs
   import spi_slave_pkg::*;
#(
   parameter logic [7:0] ID_VALUE    = 8'hA5,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                   mclk_i_clk,
   input  logic                   mclk_reset_reset,
   spi_slave_regs_if.slave        spi_signals,
   input  logic [31:0]            status_i,
   output logic [63:0]            cfg_regs_o,
   output logic                   wr_strobe_o,
   output logic [2:0]             wr_addr_o
);

   logic sclk_s, sclk_rise, sclk_fall;
   logic mosi_s, mosi_rise, mosi_fall;
   logic ss_s, ss_rise, ss_fall;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(mclk_i_clk), .rst(mclk_reset_reset), .d_i(spi_signals.SCLK),
      .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall));

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(mclk_i_clk), .rst(mclk_reset_reset), .d_i(spi_signals.MOSI),
      .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall));

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
      .clk(mclk_i_clk), .rst(mclk_reset_reset), .d_i(spi_signals.SS_n),
      .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall));

   logic unused_ok;
   assign unused_ok = &{1'b0, sclk_s, mosi_rise, mosi_fall, ss_rise};

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       rx_q, rx_d;
   logic             rnw_q, rnw_d;
   logic [6:0]       addr_q, addr_d;
   logic [7:0]       tx_q, tx_d;
   logic             miso_q, miso_d;
   logic [63:0]      cfg_q, cfg_d;
   logic             wr_strobe_q, wr_strobe_d;
   logic [2:0]       wr_addr_q, wr_addr_d;
   logic [7:0]       shift_byte;

   // Byte as it stands after the bit arriving on this rising edge is shifted in.
   assign shift_byte = {rx_q[6:0], mosi_s};

   always_ff @(posedge mclk_i_clk) begin
      if (mclk_reset_reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rx_q        <= '0;
         rnw_q       <= 1'b0;
         addr_q      <= '0;
         tx_q        <= '0;
         miso_q      <= 1'b0;
         cfg_q       <= '0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_q        <= rx_d;
         rnw_q       <= rnw_d;
         addr_q      <= addr_d;
         tx_q        <= tx_d;
         miso_q      <= miso_d;
         cfg_q       <= cfg_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rx_d        = rx_q;
      rnw_d       = rnw_q;
      addr_d      = addr_q;
      tx_d        = tx_q;
      miso_d      = 1'b0;
      cfg_d       = cfg_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;

      case (state_q)
         ST_IDLE: begin
            if (ss_fall) begin
               state_d = ST_CMD;
               cnt_d   = '0;
               rx_d    = '0;
               tx_d    = '0;
            end
         end

         ST_CMD: begin
            if (ss_s) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (sclk_rise) begin
               rx_d  = shift_byte;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == CNT_W'(CMD_W - 1)) begin
                  state_d = ST_DATA;
                  rnw_d   = shift_byte[7];
                  addr_d  = shift_byte[6:0];
                  // Read data and status are frozen here for the rest of the frame.
                  tx_d    = shift_byte[7] ?
                            read_byte(shift_byte[6:0], cfg_q, status_i, ID_VALUE) : 8'h00;
               end
            end
         end

         ST_DATA: begin
            if (ss_s) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               miso_d = miso_q;
               if (sclk_rise) begin
                  rx_d  = shift_byte;
                  cnt_d = cnt_q + 5'd1;
                  if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                     state_d = ST_DONE;
                     miso_d  = 1'b0;
                     if (!rnw_q && (addr_q[6:3] == CFG_BASE[6:3])) begin
                        cfg_d[{addr_q[2:0], 3'b000} +: 8] = shift_byte;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = addr_q[2:0];
                     end
                  end
               end else if (sclk_fall) begin
                  miso_d = tx_q[7];
                  tx_d   = {tx_q[6:0], 1'b0};
               end
            end
         end

         ST_DONE: begin
            if (ss_s) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign spi_signals.MISO    = miso_q;
   assign spi_signals.MISO_oe = ~ss_s;
   assign cfg_regs_o          = cfg_q;
   assign wr_strobe_o         = wr_strobe_q;
   assign wr_addr_o           = wr_addr_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: 50 MHz system clock, 5 MHz SPI master driven from tasks,
// results compared with a register-map model kept in arrays.
`timescale 1ns/1ps
module tb_spi_slave_regs;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] status;
   logic [63:0] cfg;
   logic        strb;
   logic [2:0]  waddr;

   always #10 clk = ~clk;

   spi_slave_regs_if spi ();

   spi_slave_regs #(.ID_VALUE(8'hA5), .SYNC_STAGES(2)) dut (
      .mclk_i_clk       (clk),
      .mclk_reset_reset (rst),
      .spi_signals      (spi),
      .status_i         (status),
      .cfg_regs_o       (cfg),
      .wr_strobe_o      (strb),
      .wr_addr_o        (waddr)
   );

   int total = 0;
   int bad   = 0;

   int         strobe_cnt = 0;
   logic [2:0] last_waddr = 3'd0;

   always @(negedge clk) begin
      if (strb === 1'b1) begin
         strobe_cnt = strobe_cnt + 1;
         last_waddr = waddr;
      end
   end

   // Register-map model.
   logic [7:0] cfg_m [8];
   localparam logic [7:0] ID_M = 8'hA5;

   function automatic logic [7:0] model_read(input int a);
      if (a < 8)                 return cfg_m[a];
      else if (a >= 8 && a < 12) return 8'((status >> (8 * (a - 8))) & 32'hFF);
      else if (a == 127)         return ID_M;
      else                       return 8'h00;
   endfunction

   function automatic logic [63:0] model_cfg();
      logic [63:0] v;
      for (int k = 0; k < 8; k++) v[8*k +: 8] = cfg_m[k];
      return v;
   endfunction

   // A full frame only commits when at least 16 edges were clocked.
   function automatic void model_frame(input logic [15:0] f, input int nedges);
      if (nedges >= 16 && f[15] == 1'b0 && f[14:8] < 8) cfg_m[f[10:8]] = f[7:0];
   endfunction

   // SPI master, mode 0: MOSI set while SCLK low, MISO sampled at each rising edge.
   task automatic xfer(input logic [15:0] tx, input int nedges, input bit raise,
                       output logic [31:0] rxb, output logic oe_seen);
      rxb     = '0;
      oe_seen = 1'b0;
      @(negedge clk); #3;
      spi.SS_n = 1'b0;
      #200;
      for (int i = 0; i < nedges; i++) begin
         spi.MOSI = (i < 16) ? tx[15-i] : 1'b0;
         #100 spi.SCLK = 1'b1;
         rxb = {rxb[30:0], spi.MISO};
         if (i == 4) oe_seen = spi.MISO_oe;
         #100 spi.SCLK = 1'b0;
      end
      if (raise) begin
         #100;
         spi.MOSI = 1'b0;
         spi.SS_n = 1'b1;
         #300;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      spi.SS_n = 1'b1; spi.SCLK = 1'b0; spi.MOSI = 1'b0;
      status = 32'h0;
      for (int k = 0; k < 8; k++) cfg_m[k] = 8'h00;
      repeat (5) @(negedge clk);
      total++; if (cfg !== 64'h0) begin bad++; $display("FAIL reset_cfg: got %h want 0", cfg); end
      total++; if (strb !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b want 0", strb); end
      total++; if (waddr !== 3'd0) begin bad++; $display("FAIL reset_waddr: got %0d want 0", waddr); end
      total++; if (spi.MISO !== 1'b0) begin bad++; $display("FAIL reset_miso: got %b want 0", spi.MISO); end
      total++; if (spi.MISO_oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", spi.MISO_oe); end
      rst = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_write();
      logic [31:0] rx; logic oe; int s0;
      s0 = strobe_cnt;
      xfer(16'h0312, 16, 1'b1, rx, oe);
      model_frame(16'h0312, 16);
      total++; if (cfg[31:24] !== 8'h12) begin bad++; $display("FAIL write_byte3: got %h want 12", cfg[31:24]); end
      total++; if (strobe_cnt - s0 != 1) begin bad++; $display("FAIL write_strobes: got %0d want 1", strobe_cnt - s0); end
      total++; if (last_waddr !== 3'd3) begin bad++; $display("FAIL write_addr: got %0d want 3", last_waddr); end
      total++; if (oe !== 1'b1) begin bad++; $display("FAIL write_oe: got %b want 1", oe); end
      total++; if (cfg !== model_cfg()) begin bad++; $display("FAIL write_cfg: got %h want %h", cfg, model_cfg()); end
   endtask

   task automatic test_readback();
      logic [31:0] rx; logic oe; int s0;
      s0 = strobe_cnt;
      xfer(16'h8300, 16, 1'b1, rx, oe);
      total++; if (rx[7:0] !== 8'h12) begin bad++; $display("FAIL readback_data: got %h want 12", rx[7:0]); end
      total++; if (rx[15:8] !== 8'h00) begin bad++; $display("FAIL readback_cmd_miso: got %h want 00", rx[15:8]); end
      total++; if (strobe_cnt != s0) begin bad++; $display("FAIL readback_strobe: got %0d want 0", strobe_cnt - s0); end
   endtask

   task automatic test_id_status();
      logic [31:0] rx; logic oe;
      xfer(16'hFF00, 16, 1'b1, rx, oe);
      total++; if (rx[7:0] !== 8'hA5) begin bad++; $display("FAIL id_read: got %h want a5", rx[7:0]); end
      status = 32'hDEADBEEF;
      xfer(16'h8A00, 16, 1'b1, rx, oe);
      total++; if (rx[7:0] !== 8'hAD) begin bad++; $display("FAIL status_byte2: got %h want ad", rx[7:0]); end
      xfer(16'h9000, 16, 1'b1, rx, oe);
      total++; if (rx[15:0] !== 16'h0000) begin bad++; $display("FAIL unmapped_read: got %h want 0000", rx[15:0]); end
   endtask

   task automatic test_abort();
      logic [31:0] rx; logic oe; int s0;
      s0 = strobe_cnt;
      xfer(16'h0555, 12, 1'b1, rx, oe);
      model_frame(16'h0555, 12);
      total++; if (cfg !== model_cfg()) begin bad++; $display("FAIL abort_cfg: got %h want %h", cfg, model_cfg()); end
      total++; if (strobe_cnt != s0) begin bad++; $display("FAIL abort_strobe: got %0d want 0", strobe_cnt - s0); end
      xfer(16'h0555, 16, 1'b1, rx, oe);
      model_frame(16'h0555, 16);
      total++; if (cfg[47:40] !== 8'h55) begin bad++; $display("FAIL after_abort_byte5: got %h want 55", cfg[47:40]); end
      total++; if (strobe_cnt - s0 != 1 || last_waddr !== 3'd5) begin
         bad++; $display("FAIL after_abort_strobe: got %0d/%0d want 1/5", strobe_cnt - s0, last_waddr);
      end
   endtask

   task automatic test_unmapped_overrun();
      logic [31:0] rx; logic oe; int s0;
      s0 = strobe_cnt;
      xfer(16'h2077, 16, 1'b1, rx, oe);
      model_frame(16'h2077, 16);
      total++; if (strobe_cnt != s0) begin bad++; $display("FAIL unmapped_strobe: got %0d want 0", strobe_cnt - s0); end
      total++; if (cfg !== model_cfg()) begin bad++; $display("FAIL unmapped_cfg: got %h want %h", cfg, model_cfg()); end
      s0 = strobe_cnt;
      xfer(16'h0199, 20, 1'b1, rx, oe);
      model_frame(16'h0199, 20);
      total++; if (cfg[15:8] !== 8'h99) begin bad++; $display("FAIL overrun_byte1: got %h want 99", cfg[15:8]); end
      total++; if (strobe_cnt - s0 != 1) begin bad++; $display("FAIL overrun_strobes: got %0d want 1", strobe_cnt - s0); end
      xfer(16'h8100, 20, 1'b1, rx, oe);
      total++; if (rx[19:0] !== {8'h00, 8'h99, 4'h0}) begin
         bad++; $display("FAIL overrun_read: got %h want 00990", rx[19:0]);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rx; logic oe; int s0;
      s0 = strobe_cnt;
      xfer(16'h07AB, 10, 1'b0, rx, oe);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 8; k++) cfg_m[k] = 8'h00;
      total++; if (cfg !== 64'h0) begin bad++; $display("FAIL midrst_cfg: got %h want 0", cfg); end
      total++; if (strb !== 1'b0 || waddr !== 3'd0) begin
         bad++; $display("FAIL midrst_strobe_addr: got %b/%0d want 0/0", strb, waddr);
      end
      total++; if (spi.MISO !== 1'b0 || spi.MISO_oe !== 1'b0) begin
         bad++; $display("FAIL midrst_miso: got %b/%b want 0/0", spi.MISO, spi.MISO_oe);
      end
      spi.SS_n = 1'b1; spi.SCLK = 1'b0; spi.MOSI = 1'b0;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      total++; if (strobe_cnt != s0 || cfg !== 64'h0) begin
         bad++; $display("FAIL midrst_no_commit: got %0d/%h want 0/0", strobe_cnt - s0, cfg);
      end
      xfer(16'h0455, 16, 1'b1, rx, oe);
      model_frame(16'h0455, 16);
      xfer(16'h8400, 16, 1'b1, rx, oe);
      total++; if (rx[15:0] !== 16'h0055) begin bad++; $display("FAIL midrst_recover: got %h want 0055", rx[15:0]); end
      total++; if (cfg !== model_cfg()) begin bad++; $display("FAIL midrst_cfg_after: got %h want %h", cfg, model_cfg()); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rx; logic oe; logic [7:0] d; int a;
      for (int n = 0; n < 4; n++) begin
         a = $urandom_range(0, 7);
         d = 8'($urandom);
         xfer({1'b0, 7'(a), d}, 16, 1'b1, rx, oe);
         model_frame({1'b0, 7'(a), d}, 16);
         xfer({1'b1, 7'(a), 8'h00}, 16, 1'b1, rx, oe);
         total++; if (rx[7:0] !== d) begin bad++; $display("FAIL b2b_read a=%0d: got %h want %h", a, rx[7:0], d); end
      end
   endtask

   task automatic test_random();
      logic [31:0] rx; logic oe; logic [15:0] f; int a; int s0; int exp_s; logic [7:0] exp_d;
      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 3))
            0:       a = $urandom_range(0, 7);
            1:       a = $urandom_range(8, 11);
            2:       a = 127;
            default: a = $urandom_range(0, 127);
         endcase
         status = $urandom;
         f = {1'($urandom), 7'(a), 8'($urandom)};
         s0 = strobe_cnt;
         exp_d = model_read(a);
         exp_s = (f[15] == 1'b0 && a < 8) ? 1 : 0;
         xfer(f, 16, 1'b1, rx, oe);
         model_frame(f, 16);
         if (f[15]) begin
            total++; if (rx[15:0] !== {8'h00, exp_d}) begin
               bad++; $display("FAIL rand_read f=%h: got %h want %h", f, rx[15:0], {8'h00, exp_d});
            end
         end else begin
            total++; if (strobe_cnt - s0 != exp_s || cfg !== model_cfg()) begin
               bad++; $display("FAIL rand_write f=%h: got %0d/%h want %0d/%h", f, strobe_cnt - s0, cfg, exp_s, model_cfg());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_readback();
      test_id_status();
      test_abort();
      test_unmapped_overrun();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
